// File: rtl/usb_kbd_led_ctrl_pkg.sv
// Shared definitions for the keyboard lock-LED sequencer: device types,
// LED bit positions, FSM encoding and a keycode-set helper.
package usb_kbd_led_ctrl_pkg;

  localparam logic [1:0] TYP_NONE = 2'd0;
  localparam logic [1:0] TYP_KBD  = 2'd1;

  localparam logic [7:0] KEY_ROLLOVER = 8'h01;

  localparam int unsigned LED_NUM     = 0;
  localparam int unsigned LED_CAPS    = 1;
  localparam int unsigned LED_SCROLL  = 2;
  localparam int unsigned LED_COMPOSE = 3;

  localparam int unsigned NUM_KEYS = 4;

  typedef logic [NUM_KEYS-1:0][7:0] keyset_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STROBE = 2'd1,
    ST_HOLD   = 2'd2
  } state_e;

  // True when any slot of the report carries the given usage code.
  function automatic logic key_present(input keyset_t keys, input logic [7:0] code);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < int'(NUM_KEYS); i++) begin
      hit = hit | (keys[i] == code);
    end
    return hit;
  endfunction

endpackage

// File: rtl/usb_kbd_led_ctrl_if.sv
// Connection to the usb_hid_host core: keyboard report inputs and LED update outputs.
interface usb_kbd_led_ctrl_if;
  import usb_kbd_led_ctrl_pkg::*;

  logic [1:0] usb_type;
  logic       usb_report;
  logic       usb_conerr;
  logic [7:0] key1;
  logic [7:0] key2;
  logic [7:0] key3;
  logic [7:0] key4;
  logic [3:0] leds;
  logic       update_leds_stb;

  modport master (
    output usb_type, usb_report, usb_conerr, key1, key2, key3, key4,
    input  leds, update_leds_stb
  );

  modport slave (
    input  usb_type, usb_report, usb_conerr, key1, key2, key3, key4,
    output leds, update_leds_stb
  );
endinterface

// File: rtl/usb_kbd_led_ctrl_lock_key_edge.sv
// Newly-pressed detector for one lock key: present in this report, absent in the previous.
module lock_key_edge
  import usb_kbd_led_ctrl_pkg::*;
#(
  parameter logic [7:0] CODE = 8'h00
) (
  input  keyset_t cur_keys,
  input  keyset_t prev_keys,
  output logic    rise
);

  assign rise = key_present(cur_keys, CODE) & ~key_present(prev_keys, CODE);

endmodule

// File: rtl/usb_kbd_led_ctrl.sv
// Keyboard lock-LED sequencer: toggles Num/Caps/Scroll on new presses and
// issues rate-limited LED update strobes to the usb_hid_host core.
module usb_kbd_led_ctrl
  import usb_kbd_led_ctrl_pkg::*;
#(
  parameter int unsigned HOLDOFF_CYCLES = 12000,
  parameter logic [7:0]  KEY_NUM        = 8'h53,
  parameter logic [7:0]  KEY_CAPS       = 8'h39,
  parameter logic [7:0]  KEY_SCROLL     = 8'h47
) (
  input  logic                clk,
  input  logic                reset,
  usb_kbd_led_ctrl_if.slave   bus,
  input  logic                led_set_stb,
  input  logic [2:0]          led_set,
  output logic [2:0]          lock_state,
  output logic                busy
);

  localparam int unsigned       CNT_W    = $clog2(HOLDOFF_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(HOLDOFF_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       lock_q, lock_d;
  logic             pending_q, pending_d;
  keyset_t          prev_keys_q, prev_keys_d;
  logic [1:0]       type_prev_q, type_prev_d;
  logic [3:0]       leds_q, leds_d;
  logic             stb_q, stb_d;
  logic             busy_q, busy_d;

  keyset_t    cur_keys;
  logic [2:0] rise;
  logic       disconnect, rollover, accept, reconnect, strobe_entry;

  assign cur_keys   = {bus.key4, bus.key3, bus.key2, bus.key1};
  assign disconnect = (bus.usb_type == TYP_NONE) || bus.usb_conerr;
  assign rollover   = (cur_keys == {NUM_KEYS{KEY_ROLLOVER}});
  assign accept     = bus.usb_report && (bus.usb_type == TYP_KBD) && !bus.usb_conerr && !rollover;
  assign reconnect  = (bus.usb_type == TYP_KBD) && (type_prev_q != TYP_KBD);

  lock_key_edge #(.CODE(KEY_NUM)) u_edge_num (
    .cur_keys(cur_keys), .prev_keys(prev_keys_q), .rise(rise[LED_NUM])
  );
  lock_key_edge #(.CODE(KEY_CAPS)) u_edge_caps (
    .cur_keys(cur_keys), .prev_keys(prev_keys_q), .rise(rise[LED_CAPS])
  );
  lock_key_edge #(.CODE(KEY_SCROLL)) u_edge_scroll (
    .cur_keys(cur_keys), .prev_keys(prev_keys_q), .rise(rise[LED_SCROLL])
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      lock_q      <= '0;
      pending_q   <= 1'b0;
      prev_keys_q <= '0;
      type_prev_q <= TYP_NONE;
      leds_q      <= '0;
      stb_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lock_q      <= lock_d;
      pending_q   <= pending_d;
      prev_keys_q <= prev_keys_d;
      type_prev_q <= type_prev_d;
      leds_q      <= leds_d;
      stb_q       <= stb_d;
      busy_q      <= busy_d;
    end
  end

  // Next state and holdoff counter; a disconnect aborts any update in flight.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pending_q) begin
          state_d = ST_STROBE;
          cnt_d   = CNT_LOAD;
        end
      end
      ST_STROBE: state_d = ST_HOLD;
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (disconnect) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end
  end

  // Registered FSM outputs.
  always_comb begin
    stb_d  = (state_d == ST_STROBE);
    busy_d = (state_d != ST_IDLE);
  end

  // Lock register, pending flag and LED snapshot; a host force wins over everything.
  always_comb begin
    strobe_entry = (state_q == ST_IDLE) && (state_d == ST_STROBE);
    lock_d       = lock_q;
    pending_d    = pending_q;
    prev_keys_d  = prev_keys_q;
    leds_d       = leds_q;
    type_prev_d  = bus.usb_type;
    if (strobe_entry) begin
      pending_d            = 1'b0;
      leds_d               = {1'b0, lock_q};
      leds_d[LED_COMPOSE]  = 1'b0;
    end
    if (accept) begin
      lock_d      = lock_q ^ rise;
      prev_keys_d = cur_keys;
      if (|rise) pending_d = 1'b1;
    end
    if (reconnect) pending_d = 1'b1;
    if (disconnect) begin
      lock_d      = '0;
      prev_keys_d = '0;
      pending_d   = 1'b0;
    end
    if (led_set_stb) begin
      lock_d    = led_set;
      pending_d = 1'b1;
    end
  end

  assign bus.leds            = leds_q;
  assign bus.update_leds_stb = stb_q;
  assign lock_state          = lock_q;
  assign busy                = busy_q;

endmodule

// File: tb/tb_usb_kbd_led_ctrl.sv
// Bench for usb_kbd_led_ctrl: directed scenarios plus randomized traffic
// checked against a report-level model of lock toggling and strobe pacing.
module tb_usb_kbd_led_ctrl;

  localparam int unsigned HOLD = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic       led_set_stb;
  logic [2:0] led_set;
  logic [2:0] lock_state;
  logic       busy;

  usb_kbd_led_ctrl_if ifc();

  usb_kbd_led_ctrl #(.HOLDOFF_CYCLES(HOLD)) dut (
    .clk(clk), .reset(reset), .bus(ifc),
    .led_set_stb(led_set_stb), .led_set(led_set),
    .lock_state(lock_state), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [2:0] m_lock;
  logic [3:0] m_leds;
  logic       m_stb;
  bit         m_pending;
  int         m_busy_left;
  logic [1:0] m_type_prev;
  logic [7:0] m_prev [4];
  logic [7:0] lock_codes [3] = '{8'h53, 8'h39, 8'h47};
  logic [7:0] pool [6] = '{8'h00, 8'h01, 8'h39, 8'h53, 8'h47, 8'h04};

  function automatic bit has_code(input logic [7:0] k [4], input logic [7:0] c);
    bit hit = 1'b0;
    foreach (k[i]) if (k[i] == c) hit = 1'b1;
    return hit;
  endfunction

  // One clock of the model, from the inputs sampled at the rising edge.
  task automatic model_step();
    logic [7:0] cur [4];
    logic [2:0] nl;
    bit disc, acc, rec, roll;
    cur = '{ifc.key1, ifc.key2, ifc.key3, ifc.key4};
    if (reset) begin
      m_lock = '0; m_leds = '0; m_stb = 1'b0; m_pending = 1'b0;
      m_busy_left = 0; m_type_prev = 2'd0; m_prev = '{default: 8'h00};
    end else begin
      disc = (ifc.usb_type == 2'd0) || ifc.usb_conerr;
      roll = (cur[0] == 8'h01) && (cur[1] == 8'h01) && (cur[2] == 8'h01) && (cur[3] == 8'h01);
      acc  = ifc.usb_report && (ifc.usb_type == 2'd1) && !ifc.usb_conerr && !roll;
      rec  = (ifc.usb_type == 2'd1) && (m_type_prev != 2'd1);
      nl = m_lock;
      m_stb = 1'b0;
      if (disc) begin
        nl = '0; m_prev = '{default: 8'h00}; m_pending = 1'b0; m_busy_left = 0;
      end else begin
        if (m_busy_left == 0 && m_pending) begin
          m_stb = 1'b1; m_leds = {1'b0, m_lock}; m_pending = 1'b0; m_busy_left = HOLD + 1;
        end else if (m_busy_left > 0) begin
          m_busy_left--;
        end
        if (acc) begin
          for (int i = 0; i < 3; i++)
            if (has_code(cur, lock_codes[i]) && !has_code(m_prev, lock_codes[i])) nl[i] = ~nl[i];
          m_prev = cur;
        end
        if (rec) m_pending = 1'b1;
        if (nl != m_lock) m_pending = 1'b1;
      end
      if (led_set_stb) begin
        nl = led_set; m_pending = 1'b1;
      end
      m_lock = nl;
      m_type_prev = ifc.usb_type;
    end
  endtask

  // Advance one cycle; outputs are observed on the falling edge.
  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic send_report(input logic [7:0] k1, k2, k3, k4);
    ifc.key1 = k1; ifc.key2 = k2; ifc.key3 = k3; ifc.key4 = k4;
    ifc.usb_report = 1'b1;
    cyc();
    ifc.usb_report = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin cyc(); n++; end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL wait_idle: busy=%b required 0 after %0d cycles", busy, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) cyc();
    checks++;
    if ({ifc.leds, ifc.update_leds_stb, lock_state, busy} !== 9'b0) begin
      errors++;
      $display("FAIL reset: leds=%b stb=%b lock=%b busy=%b required all 0",
               ifc.leds, ifc.update_leds_stb, lock_state, busy);
    end
    reset = 1'b0;
  endtask

  task automatic test_connect();
    int strobes = 0, busy_cycles = 0;
    ifc.usb_type = 2'd1;
    for (int i = 0; i < 40; i++) begin
      cyc();
      checks++;
      if ({ifc.leds, ifc.update_leds_stb, lock_state, busy} !== {m_leds, m_stb, m_lock, m_busy_left != 0}) begin
        errors++;
        $display("FAIL connect_model cyc %0d: got leds=%b stb=%b lock=%b busy=%b required leds=%b stb=%b lock=%b busy=%b",
                 i, ifc.leds, ifc.update_leds_stb, lock_state, busy, m_leds, m_stb, m_lock, m_busy_left != 0);
      end
      if (ifc.update_leds_stb) strobes++;
      if (busy) busy_cycles++;
    end
    checks++;
    if (strobes != 1 || busy_cycles != int'(HOLD) + 1 || ifc.leds !== 4'b0000) begin
      errors++;
      $display("FAIL connect: strobes=%0d busy_cycles=%0d leds=%b required 1, %0d, 0000",
               strobes, busy_cycles, ifc.leds, HOLD + 1);
    end
  endtask

  task automatic test_caps_toggle();
    int n;
    wait_idle();
    send_report(8'h39, 8'h00, 8'h00, 8'h00);
    checks++;
    if (lock_state !== 3'b010 || ifc.update_leds_stb !== 1'b0) begin
      errors++; $display("FAIL caps_n1: lock=%b stb=%b required 010 0", lock_state, ifc.update_leds_stb);
    end
    cyc();
    checks++;
    if (ifc.update_leds_stb !== 1'b1 || ifc.leds !== 4'b0010) begin
      errors++; $display("FAIL caps_n2: stb=%b leds=%b required 1 0010", ifc.update_leds_stb, ifc.leds);
    end
    wait_idle();
    send_report(8'h00, 8'h00, 8'h00, 8'h00);
    send_report(8'h39, 8'h00, 8'h00, 8'h00);
    checks++;
    if (lock_state !== 3'b000) begin
      errors++; $display("FAIL caps_off: lock=%b required 000", lock_state);
    end
    n = 0;
    while (ifc.update_leds_stb !== 1'b1 && n < 10) begin cyc(); n++; end
    checks++;
    if (ifc.update_leds_stb !== 1'b1 || ifc.leds !== 4'b0000) begin
      errors++; $display("FAIL caps_off_strobe: stb=%b leds=%b required 1 0000", ifc.update_leds_stb, ifc.leds);
    end
  endtask

  // Entered on the cycle of a strobe, so the reports below land inside the holdoff.
  task automatic test_multi_hold();
    int since = 0, extra = 0;
    send_report(8'h00, 8'h00, 8'h00, 8'h00); since++;
    send_report(8'h53, 8'h39, 8'h47, 8'h00); since++;
    checks++;
    if (lock_state !== 3'b111 || busy !== 1'b1) begin
      errors++; $display("FAIL multi_lock: lock=%b busy=%b required 111 1", lock_state, busy);
    end
    while (ifc.update_leds_stb !== 1'b1 && since < 80) begin cyc(); since++; end
    checks++;
    if (since < int'(HOLD) + 1 || ifc.update_leds_stb !== 1'b1 || ifc.leds !== 4'b0111) begin
      errors++; $display("FAIL multi_strobe: spacing=%0d leds=%b stb=%b required >=%0d 0111 1",
                         since, ifc.leds, ifc.update_leds_stb, HOLD + 1);
    end
    send_report(8'h53, 8'h39, 8'h47, 8'h00);
    for (int i = 0; i < 40; i++) begin cyc(); if (ifc.update_leds_stb) extra++; end
    checks++;
    if (lock_state !== 3'b111 || extra != 0) begin
      errors++; $display("FAIL multi_repeat: lock=%b extra_strobes=%0d required 111 0", lock_state, extra);
    end
  endtask

  task automatic test_rollover();
    wait_idle();
    send_report(8'h00, 8'h00, 8'h00, 8'h00);
    send_report(8'h39, 8'h00, 8'h00, 8'h00);
    send_report(8'h01, 8'h01, 8'h01, 8'h01);
    checks++;
    if (lock_state !== 3'b101) begin
      errors++; $display("FAIL rollover_ignored: lock=%b required 101", lock_state);
    end
    send_report(8'h39, 8'h00, 8'h00, 8'h00);
    checks++;
    if (lock_state !== 3'b101) begin
      errors++; $display("FAIL rollover_prev_kept: lock=%b required 101", lock_state);
    end
  endtask

  task automatic test_force();
    int n = 0;
    wait_idle();
    send_report(8'h00, 8'h00, 8'h00, 8'h00);
    ifc.key1 = 8'h39; ifc.usb_report = 1'b1;
    led_set_stb = 1'b1; led_set = 3'b101;
    cyc();
    ifc.usb_report = 1'b0; led_set_stb = 1'b0;
    checks++;
    if (lock_state !== 3'b101) begin
      errors++; $display("FAIL force_wins: lock=%b required 101", lock_state);
    end
    while (ifc.update_leds_stb !== 1'b1 && n < 40) begin cyc(); n++; end
    checks++;
    if (ifc.update_leds_stb !== 1'b1 || ifc.leds !== 4'b0101) begin
      errors++; $display("FAIL force_strobe: stb=%b leds=%b required 1 0101", ifc.update_leds_stb, ifc.leds);
    end
  endtask

  task automatic test_conerr();
    int n = 0, strobes = 0;
    wait_idle();
    led_set_stb = 1'b1; led_set = 3'b011;
    cyc();
    led_set_stb = 1'b0;
    while (ifc.update_leds_stb !== 1'b1 && n < 40) begin cyc(); n++; end
    cyc(); cyc();
    checks++;
    if (lock_state !== 3'b011 || busy !== 1'b1 || ifc.update_leds_stb !== 1'b0 || ifc.leds !== 4'b0011) begin
      errors++; $display("FAIL conerr_setup: lock=%b busy=%b stb=%b leds=%b required 011 1 0 0011",
                         lock_state, busy, ifc.update_leds_stb, ifc.leds);
    end
    ifc.usb_conerr = 1'b1;
    cyc();
    ifc.usb_conerr = 1'b0;
    checks++;
    if (lock_state !== 3'b000 || busy !== 1'b0 || ifc.update_leds_stb !== 1'b0 || ifc.leds !== 4'b0011) begin
      errors++; $display("FAIL conerr_clear: lock=%b busy=%b stb=%b leds=%b required 000 0 0 0011",
                         lock_state, busy, ifc.update_leds_stb, ifc.leds);
    end
    for (int i = 0; i < 30; i++) begin cyc(); if (ifc.update_leds_stb) strobes++; end
    checks++;
    if (strobes != 0) begin
      errors++; $display("FAIL conerr_quiet: strobes=%0d required 0", strobes);
    end
    ifc.usb_type = 2'd0;
    repeat (3) cyc();
    ifc.usb_type = 2'd1;
    for (int i = 0; i < 10; i++) begin cyc(); if (ifc.update_leds_stb) strobes++; end
    checks++;
    if (strobes != 1 || ifc.leds !== 4'b0000) begin
      errors++; $display("FAIL reenum: strobes=%0d leds=%b required 1 0000", strobes, ifc.leds);
    end
  endtask

  task automatic test_reset_mid_hold();
    int n = 0;
    wait_idle();
    led_set_stb = 1'b1; led_set = 3'b110;
    cyc();
    led_set_stb = 1'b0;
    while (ifc.update_leds_stb !== 1'b1 && n < 40) begin cyc(); n++; end
    cyc();
    reset = 1'b1;
    cyc();
    checks++;
    if ({ifc.leds, ifc.update_leds_stb, lock_state, busy} !== 9'b0) begin
      errors++; $display("FAIL reset_mid_hold: leds=%b stb=%b lock=%b busy=%b required all 0",
                         ifc.leds, ifc.update_leds_stb, lock_state, busy);
    end
    reset = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      ifc.usb_report = ($urandom_range(3) == 0);
      if ($urandom_range(9) == 0) begin
        ifc.key1 = 8'h01; ifc.key2 = 8'h01; ifc.key3 = 8'h01; ifc.key4 = 8'h01;
      end else begin
        ifc.key1 = pool[$urandom_range(5)]; ifc.key2 = pool[$urandom_range(5)];
        ifc.key3 = pool[$urandom_range(5)]; ifc.key4 = pool[$urandom_range(5)];
      end
      led_set_stb = ($urandom_range(39) == 0);
      led_set = 3'($urandom_range(7));
      ifc.usb_conerr = ($urandom_range(199) == 0);
      ifc.usb_type = ($urandom_range(299) == 0) ? 2'd0 : 2'd1;
      cyc();
      checks++;
      if ({ifc.leds, ifc.update_leds_stb, lock_state, busy} !== {m_leds, m_stb, m_lock, m_busy_left != 0}) begin
        errors++;
        $display("FAIL random_model cyc %0d: got leds=%b stb=%b lock=%b busy=%b required leds=%b stb=%b lock=%b busy=%b",
                 c, ifc.leds, ifc.update_leds_stb, lock_state, busy, m_leds, m_stb, m_lock, m_busy_left != 0);
      end
    end
    ifc.usb_report = 1'b0; led_set_stb = 1'b0; ifc.usb_conerr = 1'b0; ifc.usb_type = 2'd1;
  endtask

  initial begin
    reset = 1'b1;
    led_set_stb = 1'b0; led_set = 3'b000;
    ifc.usb_type = 2'd0; ifc.usb_report = 1'b0; ifc.usb_conerr = 1'b0;
    ifc.key1 = 8'h00; ifc.key2 = 8'h00; ifc.key3 = 8'h00; ifc.key4 = 8'h00;
    @(negedge clk);
    test_reset();
    test_connect();
    test_caps_toggle();
    test_multi_hold();
    test_rollover();
    test_force();
    test_conerr();
    test_reset_mid_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
